// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU: single-cycle logic/add/sub, iterative shift-add MUL and restoring DIV
module seq_alu #(
    parameter int SIZE = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          command,
    input  logic [SIZE-1:0]     a,
    input  logic [SIZE-1:0]     b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*SIZE-1:0]   result,
    output logic                overflow,
    output logic                illegal
);
    localparam int CW = $clog2(SIZE + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t              state_q, state_d;
    logic [2*SIZE-1:0]   work_a_q, work_a_d;
    logic [SIZE-1:0]     work_b_q, work_b_d;
    logic [2*SIZE-1:0]   acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*SIZE-1:0]   result_q, result_d;
    logic                overflow_q, overflow_d;
    logic                illegal_q, illegal_d;

    logic xfer, last_step, is_mul, is_div;
    assign xfer      = in_valid && in_ready;
    assign last_step = (cnt_q == '0);
    assign is_mul    = (command == 4'd8);
    assign is_div    = (command == 4'd9) && (b != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (xfer) state_d = is_mul ? MUL : (is_div ? DIV : DONE);
            MUL:  if (last_step) state_d = DONE;
            DIV:  if (last_step) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Single-cycle operations; signed results share the unsigned adder/subtractor low bits.
    logic [SIZE:0]       add_w, sub_w;
    logic [2*SIZE-1:0]   alu_res;
    logic                alu_ovf, alu_ill;
    assign add_w = {1'b0, a} + {1'b0, b};
    assign sub_w = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (command)
            4'd0: alu_res = {{SIZE{1'b0}}, a & b};
            4'd1: alu_res = {{SIZE{1'b0}}, a | b};
            4'd2: alu_res = {{SIZE{1'b0}}, a ^ b};
            4'd3: alu_res = {{SIZE{1'b0}}, ~a};
            4'd4: begin
                alu_res = {{SIZE{1'b0}}, add_w[SIZE-1:0]};
                alu_ovf = add_w[SIZE];
            end
            4'd5: begin
                alu_res = {{SIZE{1'b0}}, add_w[SIZE-1:0]};
                alu_ovf = (a[SIZE-1] == b[SIZE-1]) && (add_w[SIZE-1] != a[SIZE-1]);
            end
            4'd6: begin
                alu_res = {{SIZE{1'b0}}, sub_w[SIZE-1:0]};
                alu_ovf = sub_w[SIZE];
            end
            4'd7: begin
                alu_res = {{SIZE{1'b0}}, sub_w[SIZE-1:0]};
                alu_ovf = (a[SIZE-1] != b[SIZE-1]) && (sub_w[SIZE-1] != a[SIZE-1]);
            end
            4'd9: begin
                alu_res = {a, {SIZE{1'b1}}};
                alu_ovf = 1'b1;
            end
            default: alu_ill = 1'b1;
        endcase
    end

    // Iterative steps: acc holds the product (MUL) or the partial remainder (DIV).
    logic [2*SIZE-1:0]   mul_acc_nxt;
    logic [SIZE:0]       div_shift, div_rem_nxt;
    logic                div_ge;
    logic [SIZE-1:0]     div_quo_nxt;
    assign mul_acc_nxt = acc_q + (work_b_q[0] ? work_a_q : '0);
    assign div_shift   = {acc_q[SIZE-1:0], work_a_q[SIZE-1]};
    assign div_ge      = (div_shift >= {1'b0, work_b_q});
    assign div_rem_nxt = div_ge ? (div_shift - {1'b0, work_b_q}) : div_shift;
    assign div_quo_nxt = {work_a_q[SIZE-2:0], div_ge};

    always_comb begin
        work_a_d   = work_a_q;
        work_b_d   = work_b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        illegal_d  = illegal_q;
        case (state_q)
            IDLE: if (xfer) begin
                work_a_d = {{SIZE{1'b0}}, a};
                work_b_d = b;
                acc_d    = '0;
                cnt_d    = CW'(SIZE - 1);
                if (!is_mul && !is_div) begin
                    result_d   = alu_res;
                    overflow_d = alu_ovf;
                    illegal_d  = alu_ill;
                end
            end
            MUL: begin
                acc_d    = mul_acc_nxt;
                work_a_d = work_a_q << 1;
                work_b_d = work_b_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (last_step) begin
                    result_d   = mul_acc_nxt;
                    overflow_d = 1'b0;
                    illegal_d  = 1'b0;
                end
            end
            DIV: begin
                acc_d                  = '0;
                acc_d[SIZE:0]          = div_rem_nxt;
                work_a_d[SIZE-1:0]     = div_quo_nxt;
                cnt_d                  = cnt_q - CW'(1);
                if (last_step) begin
                    result_d   = {div_rem_nxt[SIZE-1:0], div_quo_nxt};
                    overflow_d = 1'b0;
                    illegal_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_a_q   <= '0;
            work_b_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            work_a_q   <= work_a_d;
            work_b_q   <= work_b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
        end
    end

    assign result   = result_q;
    assign overflow = overflow_q;
    assign illegal  = illegal_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard bench for seq_alu with directed and random operations
module tb_seq_alu;
    localparam int SIZE = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        command = '0;
    logic [SIZE-1:0]   a = '0;
    logic [SIZE-1:0]   b = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [2*SIZE-1:0] result;
    logic              overflow;
    logic              illegal;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t sb[$];

    seq_alu #(.SIZE(SIZE)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .command(command), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
        exp_t m;
        int sx, sy, r;
        m.res = '0; m.ovf = 1'b0; m.ill = 1'b0; m.lat = 1;
        sx = $signed(x);
        sy = $signed(y);
        case (c)
            4'd0: m.res = {8'h00, x & y};
            4'd1: m.res = {8'h00, x | y};
            4'd2: m.res = {8'h00, x ^ y};
            4'd3: m.res = {8'h00, ~x};
            4'd4: begin r = int'(x) + int'(y); m.res = 16'(r & 255); m.ovf = (r > 255); end
            4'd5: begin r = sx + sy; m.res = 16'(r & 255); m.ovf = (r > 127) || (r < -128); end
            4'd6: begin r = int'(x) - int'(y); m.res = 16'(r & 255); m.ovf = (x < y); end
            4'd7: begin r = sx - sy; m.res = 16'(r & 255); m.ovf = (r > 127) || (r < -128); end
            4'd8: begin m.res = 16'(int'(x) * int'(y)); m.lat = 9; end
            4'd9: begin
                if (y == 8'd0) begin
                    m.res = {x, 8'hFF}; m.ovf = 1'b1;
                end else begin
                    m.res = {8'(x % y), 8'(x / y)}; m.lat = 9;
                end
            end
            default: m.ill = 1'b1;
        endcase
        return m;
    endfunction

    task automatic do_op(input logic [3:0] cmd, input logic [7:0] av, input logic [7:0] bv, input int hold);
        exp_t e;
        int lat;
        logic bad;
        logic [15:0] held;
        lat = 0;
        while (!in_ready && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("in_ready_before_op", 32'(in_ready), 32'd1);
        command = cmd; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(model(cmd, av, bv));
        #1;
        in_valid = 1'b0;
        lat = 1;
        bad = 1'b0;
        while (!out_valid && lat < 50) begin
            if (in_ready) bad = 1'b1;
            in_valid = 1'($urandom); command = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
            @(posedge clk); #1; lat++;
        end
        in_valid = 1'b0;
        chk("busy_in_ready_low", 32'(bad), 32'd0);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk($sformatf("latency_cmd%0d", cmd), 32'(lat), 32'(e.lat));
            chk($sformatf("result_cmd%0d_%h_%h", cmd, av, bv), 32'(result), 32'(e.res));
            chk($sformatf("overflow_cmd%0d", cmd), 32'(overflow), 32'(e.ovf));
            chk($sformatf("illegal_cmd%0d", cmd), 32'(illegal), 32'(e.ill));
        end
        held = result;
        bad = 1'b0;
        repeat (hold) begin
            in_valid = 1'($urandom); a = 8'($urandom);
            @(posedge clk); #1;
            if (!out_valid || result !== held || in_ready) bad = 1'b1;
        end
        in_valid = 1'b0;
        chk("done_hold_stable", 32'(bad), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic bad;
        #12;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        do_op(4'd4, 8'hFF, 8'h01, 0);
        do_op(4'd7, 8'h80, 8'h01, 0);
        do_op(4'd6, 8'h03, 8'h05, 0);
        do_op(4'd8, 8'hFF, 8'hFF, 0);
        do_op(4'd9, 8'd100, 8'd7, 0);
        do_op(4'd9, 8'd100, 8'd0, 0);
        do_op(4'd5, 8'h7F, 8'h01, 0);
        do_op(4'd3, 8'hA5, 8'h00, 0);
        do_op(4'd8, 8'h0D, 8'hB3, 5);
        do_op(4'd9, 8'hFF, 8'h01, 0);
        do_op(4'd9, 8'h05, 8'h09, 0);
        for (int i = 0; i < 16; i++)
            do_op(4'(i), 8'($urandom), 8'($urandom), 0);
        for (int i = 0; i < 12; i++)
            do_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), i % 3);

        // Abort an in-flight multiply with an asynchronous reset pulse.
        command = 4'd8; a = 8'h37; b = 8'h5A; in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(model(4'd8, 8'h37, 8'h5A));
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_result", 32'(result), 32'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("postreset_in_ready", 32'(in_ready), 32'd1);
        bad = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) bad = 1'b1;
        end
        chk("postreset_no_stale", 32'(bad), 32'd0);

        do_op(4'd12, 8'h12, 8'h34, 0);
        do_op(4'd15, 8'hFF, 8'hFF, 0);
        do_op(4'd0, 8'hF0, 8'h3C, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
